// File: rtl/pipe_skid_buffer_pkg.sv
// Shared definitions for the pipeline skid buffer: occupancy state encoding
// and the default payload width.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// Valid/ready handshake bundle carried between two pipeline stages through
// the skid buffer; the slave side belongs to the buffer itself.
interface pipe_skid_buffer_if #(
  parameter int WIDTH = pipe_pkg::DEFAULT_WIDTH
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
  );

endinterface

// File: rtl/pipe_skid_buffer_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping,
// so long debug stalls never alias to short ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value; blocking = here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// register, plus flush, a bubble value on o_data and a stall-cycle counter.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  pipe_skid_buffer_if.slave   bus,
  output logic [CNT_W-1:0]    o_stall_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic main_vld;
  logic ready;
  logic in_xfer;
  logic out_xfer;

  // Valid bits of both registers are encoded in the occupancy state; ready
  // depends on registered state only, never on the downstream i_ready.
  assign main_vld = (state_q != ST_EMPTY);
  assign ready    = (state_q != ST_FULL);
  assign in_xfer  = bus.i_valid && ready;
  assign out_xfer = main_vld && bus.i_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = bus.i_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = bus.i_data;
        end else if (in_xfer) begin
          skid_d  = bus.i_data;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // The skid word always leaves before anything newer can enter.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (i_flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the payload registers carry no reset; their contents are only ever
  // observed while the state marks them valid, and o_data is masked otherwise.
  always_ff @(posedge i_clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign bus.o_valid = main_vld;
  assign bus.o_ready = ready;
  assign bus.o_data  = main_vld ? main_q : NOP_VALUE;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (main_vld && !bus.i_ready),
    .o_cnt   (o_stall_cnt)
  );

endmodule
